// File: rtl/ps2_pkg.sv
// Shared types, constants and set-2 to HID translation for the PS/2 keyboard front end.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_ESC   = 8'h29;
  localparam logic [7:0] KEY_2     = 8'h1F;
  localparam logic [7:0] KEY_P     = 8'h13;
  localparam logic [7:0] KEY_V     = 8'h19;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;

  function automatic logic [7:0] set2_to_hid(
    input logic       ext,
    input logic [7:0] code
  );
    logic [7:0] hid;
    hid = KEY_NONE;
    if (ext) begin
      case (code)
        8'h75:   hid = KEY_UP;
        8'h72:   hid = KEY_DOWN;
        8'h6B:   hid = KEY_LEFT;
        8'h74:   hid = KEY_RIGHT;
        default: hid = KEY_NONE;
      endcase
    end else begin
      case (code)
        8'h29:   hid = KEY_SPACE;
        8'h76:   hid = KEY_ESC;
        8'h1E:   hid = KEY_2;
        8'h4D:   hid = KEY_P;
        8'h2A:   hid = KEY_V;
        8'h1D:   hid = KEY_W;
        8'h1C:   hid = KEY_A;
        8'h1B:   hid = KEY_S;
        8'h23:   hid = KEY_D;
        default: hid = KEY_NONE;
      endcase
    end
    return hid;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter for one PS/2 pin.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      dout <= 1'b1;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 receiver and make/break decoder producing the held HID keycode.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int WDW = $clog2(TIMEOUT);

  logic           clk_f;
  logic           dat_f;
  logic           clk_q;
  logic           strobe;
  logic           bit_val;
  rx_state_t      state;
  rx_state_t      state_nx;
  logic [WDW-1:0] wd;
  logic           timeout;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           frame_ok;
  logic           byte_vld;
  logic [7:0]     byte_q;
  logic           ext;
  logic           brk;
  logic [7:0]     hid;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk  (Clk),
    .rst_n(Reset_n),
    .din  (PS2_CLK),
    .dout (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk  (Clk),
    .rst_n(Reset_n),
    .din  (PS2_DAT),
    .dout (dat_f)
  );

  // Strobe and its data bit are registered together so they stay aligned.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_q   <= 1'b1;
      strobe  <= 1'b0;
      bit_val <= 1'b1;
    end else begin
      clk_q   <= clk_f;
      strobe  <= clk_q & ~clk_f;
      bit_val <= dat_f;
    end
  end

  assign timeout = (state != RX_IDLE) && (wd == WDW'(TIMEOUT - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      par_bit <= 1'b0;
    end else if (strobe && state == RX_PARITY) begin
      par_bit <= bit_val;
    end
  end

  assign frame_ok = bit_val & (^{shreg, par_bit});
`else
  assign frame_ok = bit_val;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = RX_IDLE;
    end else if (strobe) begin
      unique case (state)
        RX_IDLE:   if (!bit_val) state_nx = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_nx = RX_PARITY;
        RX_PARITY: state_nx = RX_STOP;
        RX_STOP:   state_nx = RX_IDLE;
        default:   state_nx = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wd        <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_vld  <= 1'b0;
      byte_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (strobe || state == RX_IDLE) begin
        wd <= '0;
      end else begin
        wd <= wd + 1'b1;
      end
      if (timeout) begin
        frame_err <= 1'b1;
      end else if (strobe) begin
        unique case (state)
          RX_IDLE: bit_cnt <= '0;
          RX_DATA: begin
            shreg   <= {bit_val, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          RX_PARITY: ;
          RX_STOP: begin
            if (frame_ok) begin
              byte_vld <= 1'b1;
              byte_q   <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hid = set2_to_hid(ext, byte_q);

  // Last press wins; only a break of the currently shown key clears it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      keycode   <= KEY_NONE;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (byte_vld) begin
        if (byte_q == PFX_EXT) begin
          ext <= 1'b1;
        end else if (byte_q == PFX_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (hid != KEY_NONE) begin
            if (!brk) begin
              if (hid != keycode) begin
                keycode   <= hid;
                key_valid <= 1'b1;
              end
            end else if (hid == keycode) begin
              keycode   <= KEY_NONE;
              key_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
